// File: rtl/traceback_unit.sv
// Traceback walker: follows stored direction words from the best cell back to
// the alignment origin and streams one edit op per step, end-to-begin.
module traceback_unit #(
  parameter int unsigned ADDRESS_WIDTH   = 10,
  parameter int unsigned CALC_WIDTH      = 16,
  parameter int unsigned DIRECTION_WIDTH = 5,
  parameter int unsigned MAX_STEPS       = 2048
) (
  input  logic                         clk,
  input  logic                         reset_i,
  input  logic                         start,
  input  logic signed [CALC_WIDTH-1:0] max_score,
  input  logic [ADDRESS_WIDTH-1:0]     end_x,
  input  logic [ADDRESS_WIDTH-1:0]     end_y,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic                         dir_rd_en,
  output logic [2*ADDRESS_WIDTH-1:0]   dir_rd_addr,
  input  logic [DIRECTION_WIDTH-1:0]   dir_rd_data,
  output logic                         op_valid,
  input  logic                         op_ready,
  output logic [1:0]                   op_code,
  output logic                         op_last,
  output logic [ADDRESS_WIDTH-1:0]     begin_x,
  output logic [ADDRESS_WIDTH-1:0]     begin_y,
  output logic [ADDRESS_WIDTH:0]       op_count
);

  localparam int unsigned AW = ADDRESS_WIDTH;
  localparam int unsigned DW = DIRECTION_WIDTH;
  localparam int unsigned CW = ADDRESS_WIDTH + 1;
  localparam int unsigned SW = $clog2(MAX_STEPS + 1);

  localparam logic [1:0] OP_M = 2'd0;
  localparam logic [1:0] OP_I = 2'd1;
  localparam logic [1:0] OP_D = 2'd2;

  localparam logic [DW-1:0] DIR_VERT_A = DW'(5'b00011);
  localparam logic [DW-1:0] DIR_VERT_B = DW'(5'b01011);
  localparam logic [DW-1:0] DIR_HORZ_A = DW'(5'b00111);
  localparam logic [DW-1:0] DIR_HORZ_B = DW'(5'b01111);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    DECODE,
    EMIT,
    FINISH
  } state_t;

  typedef enum logic [1:0] {
    GAP_NONE,
    GAP_VERT,
    GAP_HORZ
  } gap_t;

  state_t          state;
  gap_t            gap_mode;
  logic [DW-1:0]   dir_reg;
  logic [AW-1:0]   row;
  logic [AW-1:0]   col;
  logic [SW-1:0]   step_cnt;
  logic            wd_hit;

  logic            is_diag;
  logic            is_vert;
  logic            is_horz;
  logic            row_nz;
  logic            col_nz;
  logic            score_nonpos;

  logic            dec_emit;
  logic            dec_retry;
  logic [1:0]      dec_code;
  gap_t            dec_gap;
  logic            dec_wd;
  logic            dec_last;
  logic [2*AW-1:0] dec_pos;
  logic [2*AW-1:0] hs_pos;

  // Position after taking one op from (r, c); callers guarantee no underflow.
  function automatic logic [2*AW-1:0] step_pos(input logic [1:0]    code,
                                               input logic [AW-1:0] r,
                                               input logic [AW-1:0] c);
    logic [AW-1:0] nr;
    logic [AW-1:0] nc;
    nr = (code != OP_D) ? r - AW'(1) : r;
    nc = (code != OP_I) ? c - AW'(1) : c;
    return {nr, nc};
  endfunction

  assign is_diag      = dir_reg[4];
  assign is_vert      = (dir_reg == DIR_VERT_A) || (dir_reg == DIR_VERT_B);
  assign is_horz      = (dir_reg == DIR_HORZ_A) || (dir_reg == DIR_HORZ_B);
  assign row_nz       = (row != '0);
  assign col_nz       = (col != '0);
  assign score_nonpos = max_score[CALC_WIDTH-1] || (max_score == '0);

  // Direction decode; an op that would step off row/col 0 is treated as a stop.
  always_comb begin
    dec_emit  = 1'b0;
    dec_retry = 1'b0;
    dec_code  = OP_M;
    dec_gap   = GAP_NONE;
    if (gap_mode == GAP_NONE) begin
      if (is_diag && row_nz && col_nz) begin
        dec_emit = 1'b1;
        dec_code = OP_M;
      end else if (is_vert && row_nz) begin
        dec_emit = 1'b1;
        dec_code = OP_I;
        dec_gap  = GAP_VERT;
      end else if (is_horz && col_nz) begin
        dec_emit = 1'b1;
        dec_code = OP_D;
        dec_gap  = GAP_HORZ;
      end
    end else if ((gap_mode == GAP_VERT) && is_vert && row_nz) begin
      dec_emit = 1'b1;
      dec_code = OP_I;
      dec_gap  = GAP_VERT;
    end else if ((gap_mode == GAP_HORZ) && is_horz && col_nz) begin
      dec_emit = 1'b1;
      dec_code = OP_D;
      dec_gap  = GAP_HORZ;
    end else begin
      dec_retry = 1'b1;
    end
  end

  assign dec_pos  = step_pos(dec_code, row, col);
  assign hs_pos   = step_pos(op_code, row, col);
  assign dec_wd   = (step_cnt == SW'(MAX_STEPS - 1));
  assign dec_last = (dec_pos[2*AW-1:AW] == '0) || (dec_pos[AW-1:0] == '0) || dec_wd;

  // Walk controller with registered outputs.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      state       <= IDLE;
      gap_mode    <= GAP_NONE;
      dir_reg     <= '0;
      row         <= '0;
      col         <= '0;
      step_cnt    <= '0;
      wd_hit      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      dir_rd_en   <= 1'b0;
      dir_rd_addr <= '0;
      op_valid    <= 1'b0;
      op_code     <= '0;
      op_last     <= 1'b0;
      begin_x     <= '0;
      begin_y     <= '0;
      op_count    <= '0;
    end else begin
      done      <= 1'b0;
      dir_rd_en <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            error    <= 1'b0;
            op_count <= '0;
            step_cnt <= '0;
            wd_hit   <= 1'b0;
            gap_mode <= GAP_NONE;
            if (score_nonpos) begin
              begin_x <= end_x;
              begin_y <= end_y;
              done    <= 1'b1;
              state   <= FINISH;
            end else begin
              row         <= end_y;
              col         <= end_x;
              dir_rd_addr <= {end_y, end_x};
              dir_rd_en   <= 1'b1;
              busy        <= 1'b1;
              state       <= FETCH;
            end
          end
        end
        FETCH: begin
          state <= WAIT;
        end
        WAIT: begin
          dir_reg <= dir_rd_data;
          state   <= DECODE;
        end
        DECODE: begin
          if (dec_emit) begin
            op_valid <= 1'b1;
            op_code  <= dec_code;
            op_last  <= dec_last;
            wd_hit   <= dec_wd;
            gap_mode <= dec_gap;
            state    <= EMIT;
          end else if (dec_retry) begin
            // Gap ended: re-decode the same word as a fresh cell.
            gap_mode <= GAP_NONE;
          end else begin
            begin_x <= col;
            begin_y <= row;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= FINISH;
          end
        end
        EMIT: begin
          if (op_ready) begin
            op_valid <= 1'b0;
            op_last  <= 1'b0;
            row      <= hs_pos[2*AW-1:AW];
            col      <= hs_pos[AW-1:0];
            op_count <= op_count + CW'(1);
            step_cnt <= step_cnt + SW'(1);
            if (op_last) begin
              if (wd_hit) begin
                error <= 1'b1;
              end
              begin_x <= hs_pos[AW-1:0];
              begin_y <= hs_pos[2*AW-1:AW];
              done    <= 1'b1;
              busy    <= 1'b0;
              state   <= FINISH;
            end else begin
              dir_rd_addr <= hs_pos;
              dir_rd_en   <= 1'b1;
              state       <= FETCH;
            end
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_traceback_unit.sv
// Scoreboard bench for traceback_unit: a path-level reference model fills the
// expected op/finish queues, and a negedge monitor checks the DUT against them.
module tb_traceback_unit;

  localparam int unsigned AW = 10;
  localparam int unsigned MS = 12;
  localparam int          N  = 16;

  logic               clk = 1'b0;
  logic               reset_i;
  logic               start;
  logic signed [15:0] max_score;
  logic [AW-1:0]      end_x;
  logic [AW-1:0]      end_y;
  logic               busy;
  logic               done;
  logic               error;
  logic               dir_rd_en;
  logic [2*AW-1:0]    dir_rd_addr;
  logic [4:0]         dir_rd_data;
  logic               op_valid;
  logic               op_ready;
  logic [1:0]         op_code;
  logic               op_last;
  logic [AW-1:0]      begin_x;
  logic [AW-1:0]      begin_y;
  logic [AW:0]        op_count;

  always #5 clk = ~clk;

  traceback_unit #(
    .ADDRESS_WIDTH  (AW),
    .CALC_WIDTH     (16),
    .DIRECTION_WIDTH(5),
    .MAX_STEPS      (MS)
  ) dut (
    .clk        (clk),
    .reset_i    (reset_i),
    .start      (start),
    .max_score  (max_score),
    .end_x      (end_x),
    .end_y      (end_y),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .dir_rd_en  (dir_rd_en),
    .dir_rd_addr(dir_rd_addr),
    .dir_rd_data(dir_rd_data),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_code    (op_code),
    .op_last    (op_last),
    .begin_x    (begin_x),
    .begin_y    (begin_y),
    .op_count   (op_count)
  );

  typedef struct {
    int code;
    int last;
  } op_t;

  typedef struct {
    int bx;
    int by;
    int cnt;
    int err;
    int reads;
    int ended_last;
  } fin_t;

  op_t        op_q[$];
  fin_t       fin_q[$];
  int         hs_log[$];
  logic [4:0] mem [N][N];

  int   checks = 0;
  int   errors = 0;
  int   cyc;
  int   reads_run;
  int   ops_run;
  int   last_hs_cyc;
  int   rdy_mode;
  int   stall_cnt;
  logic       hold_pend;
  logic [1:0] held_code;
  logic       held_last;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Direction RAM: registered read, data valid the cycle after dir_rd_en.
  initial begin : ram_model
    int r;
    int c;
    dir_rd_data = '0;
    forever begin
      @(posedge clk);
      if (dir_rd_en) begin
        r = int'(dir_rd_addr[2*AW-1:AW]);
        c = int'(dir_rd_addr[AW-1:0]);
        if (r < N && c < N) dir_rd_data <= mem[r][c];
        else dir_rd_data <= '0;
      end
    end
  end

  // Consumer ready: 0 off, 1 always, 2 random, 3 stall the second op for 5 cycles.
  initial begin : ready_driver
    op_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: op_ready = 1'b0;
        1: op_ready = 1'b1;
        2: op_ready = ($urandom % 3) != 0;
        default: begin
          if (op_valid && ops_run == 1 && stall_cnt < 5) begin
            op_ready = 1'b0;
            stall_cnt++;
          end else begin
            op_ready = 1'b1;
          end
        end
      endcase
    end
  end

  // Monitor: pops expected ops on each handshake and a finish record on done.
  initial begin : monitor
    op_t  e;
    fin_t f;
    cyc = 0; reads_run = 0; ops_run = 0; last_hs_cyc = 0; hold_pend = 1'b0;
    held_code = '0; held_last = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_i) begin
        hold_pend = 1'b0;
        reads_run = 0;
        ops_run   = 0;
      end else begin
        if (dir_rd_en) reads_run++;
        if (op_last) chk("op_last_with_valid", int'(op_valid), 1);
        if (op_valid) begin
          if (hold_pend) begin
            chk("held_code", int'(op_code), int'(held_code));
            chk("held_last", int'(op_last), int'(held_last));
          end
          if (op_ready) begin
            chk("op_expected", int'(op_q.size() > 0), 1);
            if (op_q.size() > 0) begin
              e = op_q.pop_front();
              chk("op_code", int'(op_code), e.code);
              chk("op_last", int'(op_last), e.last);
            end
            chk("busy_during_op", int'(busy), 1);
            hold_pend = 1'b0;
            ops_run++;
            last_hs_cyc = cyc;
            hs_log.push_back(cyc);
          end else begin
            hold_pend = 1'b1;
            held_code = op_code;
            held_last = op_last;
          end
        end else if (hold_pend) begin
          chk("valid_held", int'(op_valid), 1);
          hold_pend = 1'b0;
        end
        if (done) begin
          chk("done_expected", int'(fin_q.size() > 0), 1);
          if (fin_q.size() > 0) begin
            f = fin_q.pop_front();
            chk("begin_x", int'(begin_x), f.bx);
            chk("begin_y", int'(begin_y), f.by);
            chk("op_count", int'(op_count), f.cnt);
            chk("error", int'(error), f.err);
            chk("ram_reads", reads_run, f.reads);
            chk("ops_left", op_q.size(), 0);
            if (f.ended_last != 0) chk("done_latency", cyc - last_hs_cyc, 1);
          end
          chk("busy_at_done", int'(busy), 0);
          reads_run = 0;
          ops_run   = 0;
        end
      end
    end
  end

  // Reference: walk the direction table by the decode rules, ignoring timing.
  task automatic model_run(input int er, input int ec, input int score);
    int   r;
    int   c;
    int   steps;
    int   reads;
    int   code;
    logic [4:0] w;
    op_t  o;
    fin_t f;
    r = er; c = ec; steps = 0; reads = 0;
    f.ended_last = 0;
    f.err = 0;
    if (score <= 0) begin
      f.bx = ec; f.by = er; f.cnt = 0; f.reads = 0;
      fin_q.push_back(f);
      return;
    end
    forever begin
      reads++;
      w = mem[r][c];
      if (w[4] && r > 0 && c > 0) code = 0;
      else if ((w == 5'b00011 || w == 5'b01011) && r > 0) code = 1;
      else if ((w == 5'b00111 || w == 5'b01111) && c > 0) code = 2;
      else break;
      if (code != 2) r--;
      if (code != 1) c--;
      steps++;
      o.code = code;
      o.last = int'(r == 0 || c == 0 || steps == int'(MS));
      op_q.push_back(o);
      if (o.last != 0) begin
        f.ended_last = 1;
        f.err = int'(steps == int'(MS));
        break;
      end
    end
    f.bx = c; f.by = r; f.cnt = steps; f.reads = reads;
    fin_q.push_back(f);
  endtask

  task automatic pulse_start(input int er, input int ec, input int score);
    @(posedge clk);
    #1;
    start = 1'b1;
    end_x = AW'(ec);
    end_y = AW'(er);
    max_score = 16'(score);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_walk(input int er, input int ec, input int score, input bit poke,
                          output int lat);
    model_run(er, ec, score);
    pulse_start(er, ec, score);
    if (poke && score > 0) pulse_start(1, 1, 77);
    lat = 0;
    while (!done && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    chk("done_seen", int'(done), 1);
    if (!done) begin
      op_q.delete();
      fin_q.delete();
      reset_i = 1'b0;
      @(posedge clk);
      #1;
      reset_i = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] rand_word();
    int k;
    k = int'($urandom % 8);
    case (k)
      0, 1, 2: rand_word = {1'b1, 4'($urandom)};
      3:       rand_word = 5'b00011;
      4:       rand_word = 5'b01011;
      5:       rand_word = 5'b00111;
      6:       rand_word = 5'b01111;
      default: rand_word = 5'($urandom);
    endcase
  endfunction

  task automatic fill_mem(input logic [4:0] w);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) mem[r][c] = w;
  endtask

  initial begin : stimulus
    int lat;
    int waited;
    reset_i = 1'b0; start = 1'b0; max_score = '0; end_x = '0; end_y = '0;
    rdy_mode = 1; stall_cnt = 0;
    fill_mem(5'b00000);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_rd_en", int'(dir_rd_en), 0);
    chk("rst_rd_addr", int'(dir_rd_addr), 0);
    chk("rst_op_valid", int'(op_valid), 0);
    chk("rst_op_last", int'(op_last), 0);
    chk("rst_op_count", int'(op_count), 0);
    chk("rst_begin_x", int'(begin_x), 0);
    chk("rst_begin_y", int'(begin_y), 0);
    @(posedge clk);
    #1;
    reset_i = 1'b1;

    // Pure diagonal with ready held high: 4-cycle op spacing.
    mem[3][3] = 5'b10000; mem[2][2] = 5'b10000; mem[1][1] = 5'b10000;
    hs_log.delete();
    run_walk(3, 3, 100, 1'b0, lat);
    chk("diag_ops", hs_log.size(), 3);
    if (hs_log.size() == 3) begin
      chk("throughput_1", hs_log[1] - hs_log[0], 4);
      chk("throughput_2", hs_log[2] - hs_log[1], 4);
    end

    // Vertical gap ending on a zero word.
    fill_mem(5'b00000);
    mem[4][2] = 5'b10000; mem[3][1] = 5'b00011; mem[2][1] = 5'b00011;
    run_walk(4, 2, 50, 1'b0, lat);

    // Backpressure on the second op.
    fill_mem(5'b00000);
    mem[3][3] = 5'b10000; mem[2][2] = 5'b10000; mem[1][1] = 5'b10000;
    stall_cnt = 0;
    rdy_mode = 3;
    run_walk(3, 3, 7, 1'b0, lat);
    chk("stall_cycles", stall_cnt, 5);
    rdy_mode = 1;

    // Non-positive scores finish immediately.
    run_walk(5, 6, 0, 1'b0, lat);
    chk("zero_score_fast", int'(lat <= 2), 1);
    run_walk(2, 9, -3, 1'b0, lat);

    // Watchdog: endless horizontal gap.
    fill_mem(5'b00111);
    run_walk(14, 14, 9, 1'b0, lat);
    repeat (3) @(negedge clk);
    chk("error_sticky", int'(error), 1);
    run_walk(3, 3, 0, 1'b0, lat);
    chk("error_cleared", int'(error), 0);

    // Reset while an op is waiting for the consumer.
    fill_mem(5'b00000);
    for (int i = 1; i <= 5; i++) mem[i][i] = 5'b10000;
    rdy_mode = 0;
    pulse_start(5, 5, 20);
    waited = 0;
    while (!op_valid && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk("reached_emit", int'(op_valid), 1);
    reset_i = 1'b0;
    #1;
    chk("abort_op_valid", int'(op_valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    op_q.delete();
    fin_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_i = 1'b1;
    rdy_mode = 1;
    run_walk(5, 5, 20, 1'b0, lat);

    // Random tables, coordinates, scores, ready and ignored restarts.
    rdy_mode = 2;
    for (int t = 0; t < 40; t++) begin
      int er;
      int ec;
      int sc;
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) mem[r][c] = rand_word();
      er = int'($urandom_range(1, 15));
      ec = int'($urandom_range(1, 15));
      sc = (($urandom % 5) == 0) ? 0 - int'($urandom % 4) : int'($urandom_range(1, 1000));
      run_walk(er, ec, sc, ($urandom % 4) == 0, lat);
    end

    repeat (5) @(posedge clk);
    chk("fin_queue_empty", fin_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
